fetch_unit: RTL and testbench

Instruction fetch stage for the ARM core. It sits directly upstream of decode and of the immediate-extension stage, and supplies the Instr field those stages consume. It also consumes the extension stage's sign-extended, shifted branch offset to compute redirect targets. It holds the PC, runs one-outstanding req/ack transactions to instruction memory, and buffers fetched words in a small prefetch FIFO with a valid/ready handshake to decode.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM encoding, the prefetch entry layout and the redirect-target helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } fetch_state_t;

    localparam logic [31:0] PC_INCR  = 32'd4;
    localparam logic [31:0] PC_AHEAD = 32'd8;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // The branch reads PC as its own address plus 8; the low bits are cleared to stay word aligned.
    function automatic logic [31:0] branch_target(input logic [31:0] branch_pc,
                                                  input logic [31:0] ext_imm);
        logic [31:0] sum;
        sum = branch_pc + PC_AHEAD + ext_imm;
        return {sum[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of the fetch stage's memory, decode and redirect signals.
// The fetch unit takes the master side; memory/decode/extension sit on the slave side.
interface fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] branch_pc;
    logic [31:0] ext_imm;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_pc, ext_imm
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, instr_ready, branch_taken, branch_pc, ext_imm
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetched {instr, pc} entries with a same-edge flush.
// The head reads as zero while empty so downstream never sees stale words.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     din,
    output fetch_entry_t     dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && !empty;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // The fetch FSM only issues a request when the push it will produce has room.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one-outstanding imem transaction, prefetch FIFO to decode,
// and branch redirects that flush the FIFO and drop any in-flight word.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic   clk,
    input  logic   reset,
    fetch_if.master bus
);

    localparam int          CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

    fetch_state_t     state;
    fetch_state_t     state_n;
    logic [31:0]      fetch_pc;
    logic [31:0]      fetch_pc_n;
    logic [31:0]      req_addr;
    logic [31:0]      req_addr_n;
    logic [31:0]      target;
    logic [31:0]      next_pc;
    logic             redirect;
    logic             ack;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_after;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign redirect    = bus.branch_taken;
    assign ack         = bus.imem_ack && (state != IDLE);
    assign target      = branch_target(bus.branch_pc, bus.ext_imm);
    assign next_pc     = fetch_pc + PC_INCR;
    assign push        = (state == REQ) && ack && !redirect;
    assign pop         = !fifo_empty && bus.instr_ready;
    assign push_entry  = '{instr: bus.imem_rdata, pc: req_addr};
    assign count_after = count + CNT_W'(push) - CNT_W'(pop);

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (push_entry),
        .dout  (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC_W;
            req_addr <= RESET_PC_W;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            req_addr <= req_addr_n;
        end
    end

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        req_addr_n = req_addr;
        case (state)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_n = target;
                    req_addr_n = target;
                    state_n    = REQ;
                end else if (!fifo_full) begin
                    req_addr_n = fetch_pc;
                    state_n    = REQ;
                end
            end
            REQ: begin
                if (ack && redirect) begin
                    fetch_pc_n = target;
                    req_addr_n = target;
                end else if (ack) begin
                    fetch_pc_n = next_pc;
                    req_addr_n = next_pc;
                    // Keep streaming only if the next word is guaranteed a slot.
                    state_n    = (count_after < CNT_W'(DEPTH)) ? REQ : IDLE;
                end else if (redirect) begin
                    fetch_pc_n = target;
                    state_n    = DISCARD;
                end
            end
            DISCARD: begin
                if (redirect) fetch_pc_n = target;
                if (ack) begin
                    req_addr_n = redirect ? target : fetch_pc;
                    state_n    = REQ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.imem_req    = (state != IDLE);
    assign bus.imem_addr   = req_addr;
    assign bus.instr_valid = !fifo_empty;
    assign bus.instr       = head.instr;
    assign bus.instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch order, back-pressure, redirects, PC wrap and
// reset mid-transaction, against hand-computed addresses and memory words (word = ~addr).
module tb_fetch_unit;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   lat       = 1;
    int   cnt       = 0;
    int   stab_err  = 0;
    int   align_err = 0;
    logic force_ack = 1'b0;
    logic prev_req  = 1'b0;
    logic prev_ack  = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic ok;

    fetch_if f0 ();
    fetch_if f1 ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (f0)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (f1)
    );

    always #5 clk = ~clk;

    // Memory models: f0 acks after 'lat' cycles of request, f1 acks every requested cycle.
    initial begin
        f0.imem_ack   = 1'b0;
        f0.imem_rdata = 32'h0;
        f1.imem_ack   = 1'b0;
        f1.imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (f0.imem_req && prev_req && !prev_ack && f0.imem_addr != prev_addr) stab_err++;
            if (f0.imem_req && f0.imem_addr[1:0] != 2'b00) align_err++;
            if (reset || !f0.imem_req) begin
                cnt           = 0;
                f0.imem_ack   = force_ack;
                f0.imem_rdata = 32'hDEAD_BEEF;
            end else if (cnt >= lat - 1) begin
                cnt           = 0;
                f0.imem_ack   = 1'b1;
                f0.imem_rdata = ~f0.imem_addr;
            end else begin
                cnt++;
                f0.imem_ack = 1'b0;
            end
            prev_req      = f0.imem_req;
            prev_ack      = f0.imem_ack;
            prev_addr     = f0.imem_addr;
            f1.imem_ack   = f1.imem_req;
            f1.imem_rdata = ~f1.imem_addr;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic restart(input logic rdy, input int l);
        step();
        reset           = 1'b1;
        lat             = l;
        force_ack       = 1'b0;
        f0.instr_ready  = rdy;
        f0.branch_taken = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (f0.instr_valid) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        f0.instr_ready  = 1'b1;
        f0.branch_taken = 1'b0;
        f0.branch_pc    = 32'h0;
        f0.ext_imm      = 32'h0;
        f1.instr_ready  = 1'b1;
        f1.branch_taken = 1'b0;
        f1.branch_pc    = 32'h0;
        f1.ext_imm      = 32'h0;

        // Reset state
        step();
        step();
        check_val("rst_req",      f0.imem_req,    32'h0);
        check_val("rst_addr",     f0.imem_addr,   32'h0);
        check_val("rst_valid",    f0.instr_valid, 32'h0);
        check_val("rst_instr",    f0.instr,       32'h0);
        check_val("rst_pc",       f0.instr_pc,    32'h0);
        check_val("rst_wrap_addr", f1.imem_addr,  32'hFFFF_FFF8);
        check_val("rst_wrap_req", f1.imem_req,    32'h0);
        reset = 1'b0;

        // Streaming fetch, plus the wrapping instance on the same clock
        step();
        check_val("t1_r1_req",   f0.imem_req,    32'h1);
        check_val("t1_r1_addr",  f0.imem_addr,   32'h0);
        check_val("t1_r1_valid", f0.instr_valid, 32'h0);
        check_val("t5_r1_addr",  f1.imem_addr,   32'hFFFF_FFF8);
        step();
        check_val("t1_r2_addr",  f0.imem_addr,   32'h4);
        check_val("t1_r2_valid", f0.instr_valid, 32'h1);
        check_val("t1_r2_pc",    f0.instr_pc,    32'h0);
        check_val("t1_r2_instr", f0.instr,       32'hFFFF_FFFF);
        check_val("t5_r2_addr",  f1.imem_addr,   32'hFFFF_FFFC);
        check_val("t5_r2_pc",    f1.instr_pc,    32'hFFFF_FFF8);
        check_val("t5_r2_instr", f1.instr,       32'h0000_0007);
        step();
        check_val("t1_r3_addr",  f0.imem_addr,   32'h8);
        check_val("t1_r3_pc",    f0.instr_pc,    32'h4);
        check_val("t1_r3_instr", f0.instr,       32'hFFFF_FFFB);
        check_val("t5_r3_addr",  f1.imem_addr,   32'h0);
        check_val("t5_r3_pc",    f1.instr_pc,    32'hFFFF_FFFC);
        check_val("t5_r3_instr", f1.instr,       32'h0000_0003);
        step();
        check_val("t1_r4_addr",  f0.imem_addr,   32'hC);
        check_val("t1_r4_pc",    f0.instr_pc,    32'h8);
        check_val("t5_r4_addr",  f1.imem_addr,   32'h4);
        check_val("t5_r4_pc",    f1.instr_pc,    32'h0);

        // Back-pressure: two words buffered, request drops, resumes at 8
        restart(1'b0, 1);
        step();
        check_val("t2_r1_addr",  f0.imem_addr,   32'h0);
        step();
        check_val("t2_r2_addr",  f0.imem_addr,   32'h4);
        check_val("t2_r2_pc",    f0.instr_pc,    32'h0);
        step();
        check_val("t2_r3_req",   f0.imem_req,    32'h0);
        check_val("t2_r3_pc",    f0.instr_pc,    32'h0);
        force_ack = 1'b1;
        step();
        check_val("t2_r4_req",   f0.imem_req,    32'h0);
        force_ack = 1'b0;
        step();
        check_val("t2_r5_req",   f0.imem_req,    32'h0);
        check_val("t2_r5_pc",    f0.instr_pc,    32'h0);
        check_val("t2_r5_instr", f0.instr,       32'hFFFF_FFFF);
        f0.instr_ready = 1'b1;
        step();
        check_val("t2_r6_req",   f0.imem_req,    32'h0);
        check_val("t2_r6_pc",    f0.instr_pc,    32'h4);
        check_val("t2_r6_instr", f0.instr,       32'hFFFF_FFFB);
        step();
        check_val("t2_r7_req",   f0.imem_req,    32'h1);
        check_val("t2_r7_addr",  f0.imem_addr,   32'h8);
        check_val("t2_r7_valid", f0.instr_valid, 32'h0);
        step();
        check_val("t2_r8_pc",    f0.instr_pc,    32'h8);
        check_val("t2_r8_instr", f0.instr,       32'hFFFF_FFF7);

        // Slow memory, redirect during the request at 0x10 -> target 0x30
        restart(1'b1, 3);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (f0.imem_req && f0.imem_addr == 32'h10) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("t3_reach_0x10", ok, 32'h1);
        f0.branch_taken = 1'b1;
        f0.branch_pc    = 32'h8;
        f0.ext_imm      = 32'h20;
        step();
        f0.branch_taken = 1'b0;
        check_val("t3_b1_addr",  f0.imem_addr,   32'h10);
        check_val("t3_b1_req",   f0.imem_req,    32'h1);
        check_val("t3_b1_valid", f0.instr_valid, 32'h0);
        step();
        check_val("t3_b2_addr",  f0.imem_addr,   32'h10);
        check_val("t3_b2_valid", f0.instr_valid, 32'h0);
        step();
        check_val("t3_b3_addr",  f0.imem_addr,   32'h30);
        check_val("t3_b3_valid", f0.instr_valid, 32'h0);
        wait_valid(10, ok);
        check_val("t3_wait_valid", ok, 32'h1);
        check_val("t3_first_pc",    f0.instr_pc, 32'h30);
        check_val("t3_first_instr", f0.instr,    32'hFFFF_FFCF);

        // Redirect coinciding with an ack, negative offset back to 0x100
        restart(1'b1, 1);
        step();
        check_val("t4_r1_addr", f0.imem_addr, 32'h0);
        step();
        check_val("t4_r2_addr", f0.imem_addr, 32'h4);
        step();
        check_val("t4_r3_addr", f0.imem_addr, 32'h8);
        f0.branch_taken = 1'b1;
        f0.branch_pc    = 32'h100;
        f0.ext_imm      = 32'hFFFF_FFF8;
        step();
        f0.branch_taken = 1'b0;
        check_val("t4_r4_addr",  f0.imem_addr,   32'h100);
        check_val("t4_r4_req",   f0.imem_req,    32'h1);
        check_val("t4_r4_valid", f0.instr_valid, 32'h0);
        step();
        check_val("t4_r5_addr",  f0.imem_addr,   32'h104);
        check_val("t4_r5_pc",    f0.instr_pc,    32'h100);
        check_val("t4_r5_instr", f0.instr,       32'hFFFF_FEFF);

        // Reset while discarding a redirected request
        restart(1'b1, 3);
        for (int i = 0; i < 4; i++) step();
        check_val("t6_r4_addr", f0.imem_addr, 32'h4);
        f0.branch_taken = 1'b1;
        f0.branch_pc    = 32'h40;
        f0.ext_imm      = 32'h0;
        step();
        f0.branch_taken = 1'b0;
        check_val("t6_disc_req",   f0.imem_req,    32'h1);
        check_val("t6_disc_addr",  f0.imem_addr,   32'h4);
        check_val("t6_disc_valid", f0.instr_valid, 32'h0);
        reset = 1'b1;
        #1;
        check_val("t6_rst_req",   f0.imem_req,    32'h0);
        check_val("t6_rst_addr",  f0.imem_addr,   32'h0);
        check_val("t6_rst_valid", f0.instr_valid, 32'h0);
        check_val("t6_rst_instr", f0.instr,       32'h0);
        check_val("t6_rst_pc",    f0.instr_pc,    32'h0);
        step();
        reset = 1'b0;
        step();
        check_val("t6_rel_req",  f0.imem_req,  32'h1);
        check_val("t6_rel_addr", f0.imem_addr, 32'h0);
        wait_valid(10, ok);
        check_val("t6_wait_valid", ok, 32'h1);
        check_val("t6_first_pc",    f0.instr_pc, 32'h0);
        check_val("t6_first_instr", f0.instr,    32'hFFFF_FFFF);

        check_val("addr_stable",  stab_err,  32'h0);
        check_val("addr_aligned", align_err, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
